// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive signed products into one result, with valid/ready on both sides.
// Optional macro PRODUCT_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module product_accumulator #(
  parameter int IN_W    = 24,
  parameter int ACC_W   = 32,
  parameter int N_TERMS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic                             out_ovf,
  output logic [$clog2(N_TERMS+1)-1:0]     out_cnt
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_C       = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_cnt;

  logic signed [ACC_W:0] w_in_ext;
  logic signed [ACC_W:0] w_acc_ext;
  logic signed [ACC_W:0] w_sum;
  logic                  w_beat_ovf;
  logic [ACC_W-1:0]      w_next_acc;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_close;
  logic [ACC_W-1:0]      w_fin_acc;
  logic                  w_fin_ovf;
  logic [CNT_W-1:0]      w_fin_cnt;

  // One guard bit above the accumulator exposes signed overflow as a top-two-bit mismatch.
  assign w_in_ext   = (ACC_W+1)'($signed(in_data));
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_acc_ext + w_in_ext;
  assign w_beat_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // Overflow resolution: clamp toward the overflow direction, or keep the low bits.
  always_comb begin
    w_next_acc = w_sum[ACC_W-1:0];
`ifdef PRODUCT_ACC_SAT_EN
    if (w_beat_ovf) begin
      w_next_acc = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_next_acc = w_sum[ACC_W-1:0];
    end
`endif
  end

  assign w_accept  = in_valid && r_in_ready;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // A flush with nothing accumulated and no beat this cycle is deliberately not a close.
  assign w_close = (r_state == ST_ACCUM) &&
                   ((w_accept && (w_cnt_inc == N_C)) ||
                    (flush && ((r_cnt != CNT_ZERO) || w_accept)));

  assign w_fin_acc = w_accept ? w_next_acc : r_acc;
  assign w_fin_ovf = r_ovf | (w_accept & w_beat_ovf);
  assign w_fin_cnt = w_accept ? w_cnt_inc : r_cnt;

  // Group accumulation, result capture and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= ACC_ZERO;
      r_cnt       <= CNT_ZERO;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= ACC_ZERO;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_close) begin
            r_out_data  <= w_fin_acc;
            r_out_ovf   <= w_fin_ovf;
            r_out_cnt   <= w_fin_cnt;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_state     <= ST_HOLD;
          end else if (w_accept) begin
            r_acc <= w_next_acc;
            r_cnt <= w_cnt_inc;
            r_ovf <= w_fin_ovf;
          end else begin
            r_acc <= r_acc;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_acc       <= ACC_ZERO;
            r_cnt       <= CNT_ZERO;
            r_ovf       <= 1'b0;
            r_state     <= ST_ACCUM;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two accumulators (32-bit and 24-bit wide) share one stimulus stream and
// are checked against an integer-arithmetic reference model of the group/flush/overflow rules.
module tb_product_accumulator;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_data = 24'd0;

  logic        ready_a, valid_a, ovf_a;
  logic [31:0] data_a;
  logic [3:0]  cnt_a;
  logic        ready_b, valid_b, ovf_b;
  logic [23:0] data_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint data;
    int     cnt;
    bit     ovf;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  longint m_acc_a = 0;
  longint m_acc_b = 0;
  bit     m_ovf_a = 1'b0;
  bit     m_ovf_b = 1'b0;
  int     m_cnt = 0;
  bit     m_hold = 1'b0;

  product_accumulator #(.IN_W(24), .ACC_W(32), .N_TERMS(N)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a), .in_data(in_data),
    .flush(flush), .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
    .out_ovf(ovf_a), .out_cnt(cnt_a)
  );

  product_accumulator #(.IN_W(24), .ACC_W(24), .N_TERMS(N)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b), .in_data(in_data),
    .flush(flush), .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
    .out_ovf(ovf_b), .out_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Exact integer sum, then the overflow policy of a w-bit signed accumulator.
  function automatic longint model_add(input int w, input longint acc, input longint x,
                                       output bit o);
    longint lo;
    longint hi;
    longint s;
    lo = -(longint'(1) << (w - 1));
    hi = -lo - 1;
    s  = acc + x;
    o  = (s > hi) || (s < lo);
`ifdef PRODUCT_ACC_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    begin
      longint range;
      longint r;
      range = longint'(1) << w;
      r = (s - lo) % range;
      if (r < 0) r = r + range;
      return r + lo;
    end
`endif
  endfunction

  // One clock of stimulus; the model decides what the DUT must accept and when a group closes.
  task automatic step(input bit v, input logic [23:0] d, input bit f, input bit ordy);
    bit     o;
    longint x;
    exp_t   e;
    in_valid = v; in_data = d; flush = f; out_ready = ordy; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_a", longint'(ready_a), longint'(!m_hold));
    chk("in_ready_b", longint'(ready_b), longint'(!m_hold));
    chk("out_valid_a", longint'(valid_a), longint'(m_hold));
    chk("out_valid_b", longint'(valid_b), longint'(m_hold));
    if (!m_hold) begin
      if (v) begin
        x = longint'($signed(d));
        m_acc_a = model_add(32, m_acc_a, x, o); m_ovf_a = m_ovf_a | o;
        m_acc_b = model_add(24, m_acc_b, x, o); m_ovf_b = m_ovf_b | o;
        m_cnt++;
      end
      if ((v && m_cnt == N) || (f && m_cnt > 0)) begin
        e.data = m_acc_a; e.cnt = m_cnt; e.ovf = m_ovf_a; q_a.push_back(e);
        e.data = m_acc_b; e.cnt = m_cnt; e.ovf = m_ovf_b; q_b.push_back(e);
        m_hold = 1'b1;
        m_acc_a = 0; m_acc_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0; m_cnt = 0;
      end
    end else if (ordy) begin
      m_hold = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc_a = 0; m_acc_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0; m_cnt = 0; m_hold = 1'b0;
    q_a.delete(); q_b.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid_a"}, longint'(valid_a), 0);
    chk({tag, "_valid_b"}, longint'(valid_b), 0);
    chk({tag, "_data_a"}, longint'(data_a), 0);
    chk({tag, "_data_b"}, longint'(data_b), 0);
    chk({tag, "_cnt_a"}, longint'(cnt_a), 0);
    chk({tag, "_ovf_a"}, longint'(ovf_a), 0);
    chk({tag, "_ready_a"}, longint'(ready_a), 1);
    chk({tag, "_ready_b"}, longint'(ready_b), 1);
  endtask

  // Monitor A: while a result is presented it must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && valid_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result_a: got data %0d with empty scoreboard", $signed(data_a));
      end else begin
        chk("out_data_a", longint'($signed(data_a)), q_a[0].data);
        chk("out_cnt_a", longint'(cnt_a), longint'(q_a[0].cnt));
        chk("out_ovf_a", longint'(ovf_a), longint'(q_a[0].ovf));
        if (out_ready) void'(q_a.pop_front());
      end
    end
  end

  // Monitor B: same scoreboard discipline for the narrow accumulator.
  always @(negedge clk) begin
    if (!rst && valid_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result_b: got data %0d with empty scoreboard", $signed(data_b));
      end else begin
        chk("out_data_b", longint'($signed(data_b)), q_b[0].data);
        chk("out_cnt_b", longint'(cnt_b), longint'(q_b[0].cnt));
        chk("out_ovf_b", longint'(ovf_b), longint'(q_b[0].ovf));
        if (out_ready) void'(q_b.pop_front());
      end
    end
  end

  initial begin
    int          t1[8];
    logic signed [7:0]  a8;
    logic signed [7:0]  b8;
    logic signed [15:0] p16;
    logic [23:0] d;
    bit          v;
    bit          f;
    bit          r;

    t1 = '{-4950, -9144, -387, -5808, 8262, -9639, -9072, 1456};

    do_reset();
    check_idle_outputs("reset");

    // Full group, then one idle cycle so the single-cycle valid drops.
    for (int i = 0; i < 8; i++) step(1'b1, 24'(t1[i]), 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);

    // Backpressure with in_valid held high, then 100 + flush.
    for (int i = 0; i < 8; i++) step(1'b1, 24'(t1[i]), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 24'd77, 1'b0, 1'b0);
    step(1'b1, 24'd77, 1'b0, 1'b1);
    step(1'b1, 24'd100, 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);

    // Flush with the third beat, then flushes with nothing accumulated.
    step(1'b1, 24'(-4950), 1'b0, 1'b1);
    step(1'b1, 24'(-9144), 1'b0, 1'b1);
    step(1'b1, 24'(-387), 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b1, 1'b1);

    // Positive and negative overflow (only the 24-bit instance overflows).
    step(1'b1, 24'h7FFFFF, 1'b0, 1'b1);
    step(1'b1, 24'h000001, 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);
    step(1'b1, 24'h800000, 1'b0, 1'b1);
    step(1'b1, 24'hFFFFFF, 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 4; i++) step(1'b1, 24'd1000, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 24'd1, 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);
    step(1'b0, 24'd0, 1'b0, 1'b1);

    // Reset while a result is held.
    for (int i = 0; i < 3; i++) step(1'b1, 24'd555, 1'b0, 1'b0);
    step(1'b1, 24'd555, 1'b1, 1'b0);
    step(1'b0, 24'd0, 1'b0, 1'b0);
    step(1'b0, 24'd0, 1'b0, 1'b0);
    do_reset();
    check_idle_outputs("hold_reset");

    // Randomized mix of small products and full-range values to exercise both overflow paths.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) begin
        d = 24'($urandom);
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        p16 = a8 * b8;
        d = 24'(p16);
      end
      step(v, d, f, r);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    for (int i = 0; i < 4; i++) step(1'b0, 24'd0, 1'b0, 1'b1);

    chk("scoreboard_a_drained", longint'(q_a.size()), 0);
    chk("scoreboard_b_drained", longint'(q_b.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 signed multiplier; takes its 24-bit signed product stream and sums N_TERMS consecutive products into one dot-product result.
- Valid/ready on both sides. Result is held until the next stage accepts it.
- Reports signed overflow and optionally saturates.

Parameters:
- IN_W, 24, width of the signed product input (must be <= ACC_W).
- ACC_W, 32, width of the signed accumulator and result.
- N_TERMS, 8, number of products per result (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN_W  signed product (two's complement).
- flush  input  1  close the current group early and emit the partial sum.
- out_valid  output  1  result held on out_data.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  signed sum.
- out_ovf  output  1  overflow occurred during this group (sticky per group).
- out_cnt  output  $clog2(N_TERMS+1)  number of products in this result.

Behaviour:
- Reset state (when rst=1 at a clk edge):
  - State ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_data=0, out_ovf=0, out_cnt=0, in_ready=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready at the clk edge.
- Sign handling: in_data is sign-extended to ACC_W+1 bits and added to acc at ACC_W+1 bits.
  - Overflow = the top two bits of the sum differ.
  - Any overflow sets ovf for the rest of the group.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - On an accepted beat: acc <= sum and cnt <= cnt+1.
  - Group closes when an accepted beat makes cnt+1 == N_TERMS, or when flush=1 and (cnt>0 or a beat is accepted).
  - On close: register out_data = final sum, out_ovf = ovf | this beat's overflow, out_cnt = final count. Go to HOLD.
- Flush edge cases:
  - flush with cnt==0 and no beat accepted: ignored, stays in ACCUM.
  - flush in the same cycle as the N_TERMS-th beat: a single close, no extra result.
  - flush in the same cycle as an earlier beat: that beat is included in the result.
- State HOLD:
  - out_valid=1 and in_ready=0 (no beats accepted).
  - out_data, out_ovf and out_cnt remain stable while out_ready=0.
  - On out_ready=1: out_valid falls next cycle; acc, cnt and ovf clear; state returns to ACCUM.
  - flush is ignored in HOLD.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: N_TERMS+1 cycles per result minimum (one HOLD cycle).
- Reset mid-group or during HOLD: the partial sum and any pending result are discarded without emission.
- No internal rounding; LSB alignment of the product is preserved.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- When defined: on overflow, acc is clamped to the ACC_W signed limit in the direction of the overflow.
  - Positive limit is 2^(ACC_W-1)-1; negative limit is -2^(ACC_W-1).
  - Accumulation continues from the clamped value; out_ovf is still set.
- When undefined: acc wraps modulo 2^ACC_W (keeps the low ACC_W bits); out_ovf is set.
- No other difference in timing or ports.

Test Plan:
1. Full group:
   - Stimulus: reset, out_ready=1, then 8 back-to-back beats of the multiplier products -4950, -9144, -387, -5808, 8262, -9639, -9072, 1456.
   - Required: out_valid for one cycle, one cycle after the 8th beat; out_data=32'hFFFF8D9E (-29282); out_cnt=8; out_ovf=0; in_ready low during HOLD.
2. Backpressure:
   - Stimulus: same group with out_ready=0 for 5 cycles after out_valid rises, and in_valid held high.
   - Required: out_data stable; in_ready=0 and no beat consumed; after out_ready=1, the next group starts from 0 and the first beat 100 followed by flush gives out_data=100, out_cnt=1.
3. Flush:
   - Flush asserted with the 3rd beat (99*-50, 72*-127, -43*9) → out_data=-14481, out_cnt=3.
   - A following flush with no beats and cnt=0 → no out_valid.
4. Overflow (ACC_W=24, IN_W=24):
   - Stimulus: beats 24'h7FFFFF, 24'h000001, then flush.
   - Without macro: out_data=24'h800000, out_ovf=1.
   - With PRODUCT_ACC_SAT_EN: out_data=24'h7FFFFF, out_ovf=1.
   - Negative case: 24'h800000 + 24'hFFFFFF → wrap 24'h7FFFFF; saturate 24'h800000.
5. Reset mid-operation:
   - Stimulus: 4 beats of 1000, rst=1 for one cycle, then 8 beats of 1.
   - Required: first result out_data=8, out_cnt=8, out_ovf=0; no result emitted for the aborted group.
6. Reset during HOLD:
   - Stimulus: assert rst while out_valid=1 and out_ready=0.
   - Required: out_valid=0 and out_data=0 on the next cycle; in_ready=1.
